// File: rtl/pc_stack_unit.sv
// Program counter with call/return stack, halt/resume and sticky stack fault.
// Optional PC-relative branch is enabled by defining PC_REL_BRANCH_EN.
module pc_stack_unit #(
  parameter int ADDR_W = 16,
  parameter int STACK_DEPTH = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  localparam int DW = $clog2(STACK_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              increment,
  input  logic              jump_en,
  input  logic              call_en,
  input  logic              return_en,
  input  logic              halt_req,
  input  logic              resume,
  input  logic [ADDR_W-1:0] target,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch_offset,
  output logic [ADDR_W-1:0] pc,
  output logic              redirect,
  output logic              halted,
  output logic              fault,
  output logic              overflow,
  output logic              underflow,
  output logic              stack_empty,
  output logic              stack_full,
  output logic [DW-1:0]     depth
);
  // state | meaning
  // RUN   | one action per edge by strobe priority
  // HALT  | frozen until resume
  // FAULT | frozen until reset after stack overflow/underflow
  typedef enum logic [1:0] {RUN = 2'd0, HALT = 2'd1, FAULT = 2'd2} state_t;

  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  state_t            state, state_n;
  logic [ADDR_W-1:0] pc_n, pc_inc;
  logic [DW-1:0]     sp, sp_n;
  logic              red_n, ovf_n, unf_n, push_en;
  logic [IW-1:0]     wr_idx, rd_idx;
  logic [ADDR_W-1:0] stack_mem [STACK_DEPTH];

  assign pc_inc      = pc + ADDR_W'(1);
  assign wr_idx      = IW'(sp);
  assign rd_idx      = IW'(sp - DW'(1));
  assign stack_empty = (sp == '0);
  assign stack_full  = (sp == DW'(STACK_DEPTH));
  assign depth       = sp;
  assign halted      = (state == HALT);
  assign fault       = (state == FAULT);

`ifndef PC_REL_BRANCH_EN
  logic unused_branch;
  assign unused_branch = ^{branch_en, branch_offset};
`endif

  always_comb begin
    state_n = state;
    pc_n    = pc;
    sp_n    = sp;
    red_n   = 1'b0;
    ovf_n   = overflow;
    unf_n   = underflow;
    push_en = 1'b0;
    case (state)
      RUN: begin
        if (halt_req) begin
          state_n = HALT;
        end else if (call_en) begin
          if (stack_full) begin
            ovf_n   = 1'b1;
            state_n = FAULT;
          end else begin
            push_en = 1'b1;
            sp_n    = sp + DW'(1);
            pc_n    = target;
            red_n   = 1'b1;
          end
        end else if (return_en) begin
          if (stack_empty) begin
            unf_n   = 1'b1;
            state_n = FAULT;
          end else begin
            sp_n  = sp - DW'(1);
            pc_n  = stack_mem[rd_idx];
            red_n = 1'b1;
          end
        end else if (jump_en) begin
          pc_n  = target;
          red_n = 1'b1;
`ifdef PC_REL_BRANCH_EN
        end else if (branch_en) begin
          pc_n  = pc + branch_offset;
          red_n = 1'b1;
`endif
        end else if (increment) begin
          pc_n = pc_inc;
        end
      end
      HALT: begin
        if (resume) state_n = RUN;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= RUN;
      pc        <= RESET_PC;
      sp        <= '0;
      redirect  <= 1'b0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      state     <= state_n;
      pc        <= pc_n;
      sp        <= sp_n;
      redirect  <= red_n;
      overflow  <= ovf_n;
      underflow <= unf_n;
    end
  end

  // Return-address storage is deliberately left uninitialised by reset.
  always_ff @(posedge clk) begin
    if (push_en && !reset) stack_mem[wr_idx] <= pc_inc;
  end

endmodule

// File: doc/pc_stack_unit.md
# pc_stack_unit

Parametrised program counter for the VR16 frontend. Adds a hardware call/return stack of configurable depth, a halt/resume state machine, and a sticky fault state for stack overflow and underflow. It replaces the flat single-slot return register. It sits between the decoder's control strobes and the instruction-memory address port, and supplies the fetch address every cycle.

## Interface
Parameters:
- ADDR_W, 16: PC and address width in bits (≥4).
- STACK_DEPTH, 4: number of return-address entries (≥1).
- RESET_PC, 0: PC value loaded on reset.

Ports:
- clk  in  1  single clock; all state updates on posedge.
- reset  in  1  synchronous, active-high; sampled on posedge clk.
- increment  in  1  sequential advance, PC ← PC+1.
- jump_en  in  1  absolute jump, PC ← target.
- call_en  in  1  push PC+1, then PC ← target.
- return_en  in  1  pop the top of stack into PC.
- halt_req  in  1  enter HALT.
- resume  in  1  leave HALT.
- target  in  ADDR_W  jump/call destination.
- branch_en  in  1  relative branch (macro-dependent).
- branch_offset  in  ADDR_W  two's-complement offset (macro-dependent).
- pc  out  ADDR_W  current fetch address (registered).
- redirect  out  1  one-cycle pulse: PC was loaded non-sequentially in the previous edge.
- halted  out  1  state is HALT.
- fault  out  1  state is FAULT.
- overflow  out  1  sticky: call attempted with stack full.
- underflow  out  1  sticky: return attempted with stack empty.
- stack_empty  out  1  sp == 0.
- stack_full  out  1  sp == STACK_DEPTH.
- depth  out  $clog2(STACK_DEPTH+1)  current sp.

## Operation
- State machine: RUN, HALT, FAULT; 2-bit encoded state register.
- RUN: one action per edge, by priority halt_req > call_en > return_en > jump_en > branch_en > increment. With no input asserted, PC holds.
  - halt_req: go to HALT; PC holds.
  - call_en, not full: stack[sp] ← PC+1, sp+1, PC ← target, redirect=1.
  - call_en, full: no push, PC holds, overflow ← 1, go to FAULT.
  - return_en, not empty: PC ← stack[sp-1], sp−1, redirect=1.
  - return_en, empty: PC holds, underflow ← 1, go to FAULT.
  - jump_en: PC ← target, redirect=1; stack untouched.
  - branch_en: see Configuration.
  - increment: PC ← PC+1.
- HALT: PC and stack frozen; all control inputs except resume ignored. resume → RUN on the next edge with no PC change. halt_req together with resume is treated as resume.
- FAULT: everything frozen until reset; resume is ignored.
- Arithmetic: all PC math is modulo 2^ADDR_W. PC+1 at all-ones wraps to 0. A call at all-ones pushes 0.
- Stack storage is not cleared by reset; only sp is. Popped data is valid only for entries pushed since the last reset.

## Timing
- Reset values:
  - pc = RESET_PC
  - state = RUN
  - sp = 0
  - redirect = halted = fault = overflow = underflow = 0
  - stack_empty = 1, stack_full = 0
- reset has priority over every input, in any state including mid-call or FAULT.
- All outputs are registered and change only on posedge clk.
- Latency is one cycle: a strobe sampled at edge N is reflected in pc after edge N.
- redirect is high for exactly the cycle after a jump, call, taken return, or branch. It is low after increment, hold, and halt entry.
- stack_full, stack_empty and depth reflect sp after the same edge.
- Back-to-back call/return on consecutive cycles are fully supported with no bubble.

## Configuration
- PC_REL_BRANCH_EN defined: branch_en in RUN gives PC ← PC + branch_offset (signed, modulo 2^ADDR_W), redirect=1.
- PC_REL_BRANCH_EN undefined: branch_en and branch_offset are ignored; the ports remain so that instantiations are identical. branch_en then falls through to the next priority (increment).

## Test plan
- Reset, then increment for 3 cycles → pc 0,1,2,3; redirect 0 throughout; stack_empty=1.
- pc=0x0010, call_en with target=0x0100 → pc=0x0100, depth=1, redirect pulse. Then return_en → pc=0x0011, depth=0, redirect pulse.
- STACK_DEPTH=4: 4 nested calls → stack_full=1. A 5th call → overflow=1, fault=1, pc unchanged. Subsequent increment and resume are ignored. reset → pc=RESET_PC, fault=0, overflow=0.
- return_en with empty stack → underflow=1, fault=1, pc unchanged.
- Halt mid-stream: halt_req with increment at pc=5 → halted=1, pc=5 for 3 cycles despite jump_en. Then resume → pc=5; the next increment gives 6.
- Priority and wrap:
  - pc=0xFFFF, increment → 0x0000.
  - call_en and jump_en asserted together → call taken, depth+1.
  - With macro on: pc=0x0020, branch_offset=0xFFF0 → pc=0x0010.
  - With macro off: the same stimulus plus increment → pc=0x0021.
